// File: rtl/alu_pkg.sv
// Shared opcode, shifter-mode and FSM state definitions for the multicycle ALU.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_FWD = 4'd0;
    localparam logic [OP_W-1:0] OP_ADD = 4'd1;
    localparam logic [OP_W-1:0] OP_SUB = 4'd2;
    localparam logic [OP_W-1:0] OP_AND = 4'd3;
    localparam logic [OP_W-1:0] OP_OR  = 4'd4;
    localparam logic [OP_W-1:0] OP_XOR = 4'd5;
    localparam logic [OP_W-1:0] OP_SLL = 4'd6;
    localparam logic [OP_W-1:0] OP_SRL = 4'd7;
    localparam logic [OP_W-1:0] OP_SRA = 4'd8;
    localparam logic [OP_W-1:0] OP_ROR = 4'd9;
    localparam logic [OP_W-1:0] OP_MUL = 4'd10;

    // Shifter mode encoding
    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRL = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter: logical left/right, arithmetic right, rotate right.
// The full-width amount is unsigned; out-of-range amounts saturate except for ROR,
// which wraps modulo WIDTH.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] amount_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] result_o
);

    localparam int SHW = $clog2(WIDTH);

    logic               in_range;
    logic [SHW-1:0]     amt_lo;
    logic [2*WIDTH-1:0] rot_dbl;

    // Amount is below WIDTH exactly when no bit above the low SHW bits is set
    assign in_range = ((amount_i >> SHW) == '0);
    assign amt_lo   = amount_i[SHW-1:0];
    assign rot_dbl  = {a_i, a_i} >> amt_lo;

    // Select the shifted value for the requested mode
    always_comb begin
        result_o = '0;
        case (mode_i)
            SH_SLL: result_o = in_range ? (a_i << amt_lo) : '0;
            SH_SRL: result_o = in_range ? (a_i >> amt_lo) : '0;
            SH_SRA: result_o = in_range ? WIDTH'($signed(a_i) >>> amt_lo)
                                        : {WIDTH{a_i[WIDTH-1]}};
            default: result_o = rot_dbl[WIDTH-1:0];
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// Parametrised ALU with registered outputs, START/DONE handshake and an iterative
// shift-add multiplier. Single-cycle ops complete one cycle after accept; MUL holds
// BUSY for WIDTH cycles and completes one cycle later.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [OP_W-1:0]   SELECT,
    input  logic [WIDTH-1:0]  DATA1,
    input  logic [WIDTH-1:0]  DATA2,
    output logic [WIDTH-1:0]  RESULT,
    output logic [WIDTH-1:0]  RESULT_HI,
    output logic              ZERO,
    output logic              CARRY,
    output logic              OVERFLOW,
    output logic              ERROR,
    output logic              BUSY,
    output logic              DONE
);

    localparam int CW = SHW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    state_t             state_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      count_q;
    logic [WIDTH-1:0]   result_q, result_hi_q;
    logic               zero_q, carry_q, ovf_q, err_q, busy_q, done_q;

    // Single-cycle datapath signals
    logic               is_sub;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum_w;
    logic [1:0]         sh_mode;
    logic [WIDTH-1:0]   sh_res;
    logic [WIDTH-1:0]   res_d;
    logic               carry_d, ovf_d, err_d;

    // Multiplier step signals
    logic [CW-1:0]      pos;
    logic [2*WIDTH-1:0] pp;
    logic [2*WIDTH-1:0] acc_d;

    // Adder/subtractor shares one carry chain; SUB is A + ~B + 1
    always_comb begin
        is_sub = (SELECT == OP_SUB);
        b_eff  = is_sub ? ~DATA2 : DATA2;
        sum_w  = {1'b0, DATA1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    end

    // Map shift opcodes onto the shifter's mode field
    always_comb begin
        sh_mode = SH_SLL;
        case (SELECT)
            OP_SRL:  sh_mode = SH_SRL;
            OP_SRA:  sh_mode = SH_SRA;
            OP_ROR:  sh_mode = SH_ROR;
            default: sh_mode = SH_SLL;
        endcase
    end

    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .a_i      (DATA1),
        .amount_i (DATA2),
        .mode_i   (sh_mode),
        .result_o (sh_res)
    );

    // Result and flags of every single-cycle opcode, computed from the live inputs
    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        err_d   = 1'b0;
        case (SELECT)
            OP_FWD: res_d = DATA2;
            OP_ADD, OP_SUB: begin
                res_d   = sum_w[WIDTH-1:0];
                carry_d = sum_w[WIDTH];
                ovf_d   = (DATA1[WIDTH-1] == b_eff[WIDTH-1]) &&
                          (sum_w[WIDTH-1] != DATA1[WIDTH-1]);
            end
            OP_AND: res_d = DATA1 & DATA2;
            OP_OR:  res_d = DATA1 | DATA2;
            OP_XOR: res_d = DATA1 ^ DATA2;
            OP_SLL, OP_SRL, OP_SRA, OP_ROR: res_d = sh_res;
            default: err_d = 1'b1;
        endcase
    end

    // One partial product per cycle: LSB of the shifting B selects A placed at
    // the bit position already consumed (WIDTH - remaining count)
    always_comb begin
        pos   = CNT_FULL - count_q;
        pp    = b_q[0] ? ({{WIDTH{1'b0}}, a_q} << pos) : '0;
        acc_d = acc_q + pp;
    end

    // Control FSM with registered outputs; outputs only change on completion
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        if (SELECT == OP_MUL) begin
                            a_q     <= DATA1;
                            b_q     <= DATA2;
                            acc_q   <= '0;
                            count_q <= CNT_FULL;
                            busy_q  <= 1'b1;
                            state_q <= ST_MUL;
                        end else begin
                            result_q    <= res_d;
                            result_hi_q <= '0;
                            zero_q      <= (res_d == '0);
                            carry_q     <= carry_d;
                            ovf_q       <= ovf_d;
                            err_q       <= err_d;
                            done_q      <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    acc_q   <= acc_d;
                    b_q     <= b_q >> 1;
                    count_q <= count_q - 1'b1;
                    if (count_q == CW'(1)) begin
                        result_q    <= acc_d[WIDTH-1:0];
                        result_hi_q <= acc_d[2*WIDTH-1:WIDTH];
                        zero_q      <= (acc_d == '0);
                        carry_q     <= (acc_d[2*WIDTH-1:WIDTH] != '0);
                        ovf_q       <= 1'b0;
                        err_q       <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign RESULT    = result_q;
    assign RESULT_HI = result_hi_q;
    assign ZERO      = zero_q;
    assign CARRY     = carry_q;
    assign OVERFLOW  = ovf_q;
    assign ERROR     = err_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomised and directed bench for alu_multicycle (WIDTH=8) against an
// arithmetic reference model.
module tb_alu_multicycle;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START;
    logic [3:0] SELECT;
    logic [7:0] DATA1, DATA2;
    logic [7:0] RESULT, RESULT_HI;
    logic       ZERO, CARRY, OVERFLOW, ERROR, BUSY, DONE;

    int n_checks = 0;
    int n_errors = 0;

    alu_multicycle #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .SELECT    (SELECT),
        .DATA1     (DATA1),
        .DATA2     (DATA2),
        .RESULT    (RESULT),
        .RESULT_HI (RESULT_HI),
        .ZERO      (ZERO),
        .CARRY     (CARRY),
        .OVERFLOW  (OVERFLOW),
        .ERROR     (ERROR),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Reference model: results from plain integer arithmetic
    task automatic model(input int op, input int a, input int b,
                         output int lo, output int hi,
                         output bit z, output bit c, output bit o, output bit e);
        int s, r, sa, sb, p;
        lo = 0; hi = 0; c = 0; o = 0; e = 0;
        sa = sgn(a); sb = sgn(b);
        case (op)
            0: lo = b;
            1: begin
                s = a + b; lo = s % 256; c = (s >= 256);
                o = ((sa + sb) > 127) || ((sa + sb) < -128);
            end
            2: begin
                s = a + (255 - b) + 1; lo = s % 256; c = (s >= 256);
                o = ((sa - sb) > 127) || ((sa - sb) < -128);
            end
            3: lo = a & b;
            4: lo = a | b;
            5: lo = a ^ b;
            6: lo = (b >= 8) ? 0 : ((a << b) % 256);
            7: lo = (b >= 8) ? 0 : (a >> b);
            8: lo = (b >= 8) ? ((sa < 0) ? 255 : 0) : ((sa >>> b) & 255);
            9: begin r = b % 8; lo = ((a >> r) | (a << (8 - r))) & 255; end
            10: begin p = a * b; lo = p % 256; hi = p / 256; c = (hi != 0); end
            default: e = 1;
        endcase
        z = (lo == 0) && (hi == 0);
    endtask

    task automatic check_outs(input string tag, input int lo, input int hi,
                              input bit z, input bit c, input bit o, input bit e);
        check({tag, "_done"}, DONE, 1);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_res"}, RESULT, lo);
        check({tag, "_hi"}, RESULT_HI, hi);
        check({tag, "_zero"}, ZERO, z);
        check({tag, "_carry"}, CARRY, c);
        check({tag, "_ovf"}, OVERFLOW, o);
        check({tag, "_err"}, ERROR, e);
    endtask

    // Issue one op, wait for DONE within a bound, check latency, BUSY span and outputs
    task automatic run_op(input int op, input int a, input int b, input string tag);
        int lo, hi, lat, busy_cnt;
        bit z, c, o, e;
        model(op, a, b, lo, hi, z, c, o, e);
        @(negedge CLK);
        START = 1'b1; SELECT = 4'(op); DATA1 = 8'(a); DATA2 = 8'(b);
        @(posedge CLK); #1;
        START = 1'b0;
        lat = 1; busy_cnt = 0;
        while (!DONE && lat < 40) begin
            if (BUSY) busy_cnt++;
            @(posedge CLK); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, (op == 10) ? 9 : 1);
        check({tag, "_busycnt"}, busy_cnt, (op == 10) ? 8 : 0);
        check_outs(tag, lo, hi, z, c, o, e);
        $display("op=%0d a=%02h b=%02h -> res=%02h hi=%02h z=%0b c=%0b v=%0b e=%0b lat=%0d",
                 op, a, b, RESULT, RESULT_HI, ZERO, CARRY, OVERFLOW, ERROR, lat);
    endtask

    initial begin
        int lo, hi, lat, busy_cnt, op, a, b;
        bit z, c, o, e, saw_done;

        RESET = 1'b1; START = 1'b0; SELECT = '0; DATA1 = '0; DATA2 = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_res", RESULT, 0);
        check("rst_hi", RESULT_HI, 0);
        check("rst_flags", {ZERO, CARRY, OVERFLOW, ERROR, BUSY, DONE}, 0);
        @(negedge CLK); RESET = 1'b0;

        // Directed cases
        run_op(1, 8'hFF, 8'h01, "add_ff_01");
        @(posedge CLK); #1;
        check("done_one_cycle", DONE, 0);
        run_op(2, 8'h80, 8'h01, "sub_80_01");
        run_op(2, 8'h00, 8'h01, "sub_00_01");
        run_op(1, 8'h7F, 8'h01, "add_7f_01");
        run_op(8, 8'h90, 2, "sra_90_2");
        run_op(7, 8'h90, 9, "srl_90_9");
        run_op(9, 8'h81, 9, "ror_81_9");
        run_op(6, 8'h01, 7, "sll_01_7");
        run_op(8, 8'h90, 200, "sra_90_200");
        run_op(12, 8'h55, 8'hAA, "inv_12");
        run_op(0, 8'h12, 8'h34, "fwd");

        // MUL FF x FF with a dropped START during BUSY and a START in the DONE cycle
        model(10, 255, 255, lo, hi, z, c, o, e);
        @(negedge CLK);
        START = 1'b1; SELECT = 4'd10; DATA1 = 8'hFF; DATA2 = 8'hFF;
        @(posedge CLK); #1;
        START = 1'b0;
        lat = 1; busy_cnt = 0;
        while (!DONE && lat < 40) begin
            if (BUSY) busy_cnt++;
            if (lat == 3) begin
                START = 1'b1; SELECT = 4'd1; DATA1 = 8'h01; DATA2 = 8'h01;
            end else begin
                START = 1'b0;
            end
            @(posedge CLK); #1;
            lat++;
        end
        check("mulff_lat", lat, 9);
        check("mulff_busycnt", busy_cnt, 8);
        check_outs("mulff", lo, hi, z, c, o, e);
        $display("op=10 a=ff b=ff -> res=%02h hi=%02h c=%0b lat=%0d", RESULT, RESULT_HI, CARRY, lat);
        START = 1'b1; SELECT = 4'd1; DATA1 = 8'h01; DATA2 = 8'h01;
        @(posedge CLK); #1;
        START = 1'b0;
        check("done_cycle_start_done", DONE, 1);
        check("done_cycle_start_res", RESULT, 8'h02);
        check("done_cycle_start_hi", RESULT_HI, 0);
        $display("op=1 a=01 b=01 (in DONE cycle) -> res=%02h", RESULT);
        @(posedge CLK); #1;
        check("done_cycle_start_pulse", DONE, 0);

        // Reset during MUL 0F x 0F
        @(negedge CLK);
        START = 1'b1; SELECT = 4'd10; DATA1 = 8'h0F; DATA2 = 8'h0F;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK); RESET = 1'b1;
        @(posedge CLK); #1;
        check("midrst_res", RESULT, 0);
        check("midrst_flags", {ZERO, CARRY, OVERFLOW, ERROR, BUSY, DONE}, 0);
        @(negedge CLK); RESET = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            if (DONE || BUSY) saw_done = 1'b1;
        end
        check("midrst_no_done", saw_done, 0);
        $display("reset during MUL 0f*0f -> aborted");
        run_op(10, 8'h03, 8'h05, "mul_03_05");

        // Back-to-back single-cycle ops, one DONE per cycle
        for (int i = 0; i < 24; i++) begin
            op = $urandom_range(0, 14);
            if (op >= 10) op = op + 1;
            a = $urandom_range(0, 255);
            b = (op >= 6 && op <= 9) ? $urandom_range(0, 20) : $urandom_range(0, 255);
            model(op, a, b, lo, hi, z, c, o, e);
            @(negedge CLK);
            START = 1'b1; SELECT = 4'(op); DATA1 = 8'(a); DATA2 = 8'(b);
            @(posedge CLK); #1;
            check_outs("b2b", lo, hi, z, c, o, e);
            $display("b2b op=%0d a=%02h b=%02h -> res=%02h", op, a, b, RESULT);
        end
        @(negedge CLK); START = 1'b0;

        // Random ops through the full handshake, including MUL
        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 15);
            a = $urandom_range(0, 255);
            b = (op >= 6 && op <= 9) ? $urandom_range(0, 20) : $urandom_range(0, 255);
            run_op(op, a, b, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
